// File: rtl/game_round_ctrl.sv
// game_round_ctrl
// Match sequencer that sits above the physics engine. It paces the engine
// with a one-cycle update strobe per frame, requests an engine re-init
// before every rally, keeps both players' scores, holds a dead-time pause
// after each point and declares the match winner. It also owns the start
// and pause buttons.
module game_round_ctrl #(
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 15,
    parameter int unsigned DIV_W        = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       phys_valid,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    output logic       phys_en,
    output logic       phys_reinit,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] last_point,
    output logic [1:0] match_winner,
    output logic [2:0] state_o,
    output logic       paused
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REINIT     = 3'd1,
        PLAY       = 3'd2,
        POINT_WAIT = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [7:0]       PAUSE_LOAD = 8'(PAUSE_FRAMES);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       wait_q, wait_d;
    logic [3:0]       p1_q, p1_d;
    logic [3:0]       p2_q, p2_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       winner_q, winner_d;
    logic             paused_q, paused_d;
    logic             phys_en_q, phys_en_d;

    logic             frame_tick;
    logic             point_hit;
    logic [3:0]       p1_inc;
    logic [3:0]       p2_inc;

    // Free-running frame divider; it only ever restarts on reset.
    always_comb begin
        frame_tick = (div_q == DIV_LAST);
        div_d      = frame_tick ? '0 : div_q + DIV_W'(1);
    end

    // Decode a usable point report and the saturated score candidates.
    always_comb begin
        point_hit = phys_valid && phys_game_over &&
                    ((phys_winner == 2'd1) || (phys_winner == 2'd2));
        p1_inc    = (p1_q == WIN) ? p1_q : p1_q + 4'd1;
        p2_inc    = (p2_q == WIN) ? p2_q : p2_q + 4'd1;
    end

    // Physics strobe is registered, so it lands the cycle after the tick.
    always_comb begin
        phys_en_d = frame_tick && (state_q == PLAY) && !paused_q;
    end

    // Next-state and match bookkeeping for the round sequencer.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        last_d   = last_q;
        winner_d = winner_q;
        paused_d = paused_q;

        case (state_q)
            IDLE: begin
                paused_d = 1'b0;
                if (start_btn) begin
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    last_d   = 2'd0;
                    winner_d = 2'd0;
                    state_d  = REINIT;
                end
            end

            REINIT: begin
                paused_d = 1'b0;
                state_d  = PLAY;
            end

            PLAY: begin
                if (point_hit) begin
                    // A point wins over a simultaneous pause press.
                    paused_d = 1'b0;
                    last_d   = phys_winner;
                    if (phys_winner == 2'd1) begin
                        p1_d = p1_inc;
                        if (p1_inc == WIN) begin
                            winner_d = 2'd1;
                            state_d  = MATCH_OVER;
                        end else begin
                            wait_d  = PAUSE_LOAD;
                            state_d = POINT_WAIT;
                        end
                    end else begin
                        p2_d = p2_inc;
                        if (p2_inc == WIN) begin
                            winner_d = 2'd2;
                            state_d  = MATCH_OVER;
                        end else begin
                            wait_d  = PAUSE_LOAD;
                            state_d = POINT_WAIT;
                        end
                    end
                end else if (pause_btn) begin
                    paused_d = ~paused_q;
                end
            end

            POINT_WAIT: begin
                paused_d = 1'b0;
                if (frame_tick) begin
                    if (wait_q == 8'd0) begin
                        state_d = REINIT;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
            end

            MATCH_OVER: begin
                paused_d = 1'b0;
                if (start_btn) begin
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    last_d   = 2'd0;
                    winner_d = 2'd0;
                    state_d  = REINIT;
                end
            end

            default: begin
                paused_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State register; reset has priority over every input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            wait_q    <= 8'd0;
            p1_q      <= 4'd0;
            p2_q      <= 4'd0;
            last_q    <= 2'd0;
            winner_q  <= 2'd0;
            paused_q  <= 1'b0;
            phys_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            wait_q    <= wait_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
            paused_q  <= paused_d;
            phys_en_q <= phys_en_d;
        end
    end

    assign phys_en      = phys_en_q;
    assign phys_reinit  = (state_q == REINIT);
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign last_point   = last_q;
    assign match_winner = winner_q;
    assign state_o      = state_q;
    assign paused       = paused_q;

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Match sequencer sitting above the physics engine.
- Generates the per-frame physics enable, and pulses a physics re-init between rallies.
- Consumes the engine's game_over/winner/valid report, keeps both players' scores, inserts a post-point pause, and declares the match winner.
- Also owns the start and pause buttons.

Parameters:
- FRAME_DIV, 833333: clk cycles per physics frame (50 MHz / 60 Hz); must be ≥ 2.
- PAUSE_FRAMES, 60: frames of dead time after each point.
- WIN_SCORE, 15: points needed to win the match (1..15).
- DIV_W, 20: width of the frame divider counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_btn  in  1  one-cycle pulse, debounced upstream
- pause_btn  in  1  one-cycle pulse, debounced upstream
- phys_valid  in  1  engine result valid (engine's valid)
- phys_game_over  in  1  engine reports the ball touched the floor
- phys_winner  in  2  engine point winner: 0 none, 1 P1, 2 P2
- phys_en  out  1  one-cycle physics update strobe
- phys_reinit  out  1  one-cycle request to restore engine initial positions
- p1_score  out  4  P1 points
- p2_score  out  4  P2 points
- last_point  out  2  winner of the most recent point (0 before first)
- match_winner  out  2  0 while match runs, else 1/2
- state_o  out  3  current FSM state encoding, for the renderer
- paused  out  1  play frozen by user

Behaviour:
- All state changes on the rising edge of clk.
- rst has priority over every input. Reset values:
  - state = IDLE
  - divider = 0
  - all outputs 0
- Frame divider:
  - Free-running 0..FRAME_DIV-1, wraps to 0.
  - frame_tick is internal and true when divider == FRAME_DIV-1.
  - Divider never stops or resets except on rst.
- phys_en is registered: it goes to 1 for exactly one cycle, the cycle after frame_tick, only when state == PLAY and paused == 0.
- State encodings: IDLE=0, REINIT=1, PLAY=2, POINT_WAIT=3, MATCH_OVER=4.
- IDLE:
  - start_btn → clear scores, last_point, match_winner; go to REINIT.
  - pause_btn is ignored.
- REINIT:
  - phys_reinit = 1 for this one cycle; paused forced to 0.
  - Next state is PLAY unconditionally.
- PLAY:
  - pause_btn toggles paused.
  - start_btn is ignored.
  - A point is scored when phys_valid && phys_game_over && phys_winner ∈ {1,2}. On that cycle:
    - Increment the corresponding score (saturates at WIN_SCORE).
    - last_point = phys_winner.
    - If the new score == WIN_SCORE: match_winner = phys_winner; go to MATCH_OVER.
    - Otherwise: load frame counter with PAUSE_FRAMES; go to POINT_WAIT.
  - phys_winner == 3, or game_over with winner 0, is ignored (no score, stay in PLAY).
  - Report arriving on the same cycle as pause_btn: the point is taken, paused is cleared, and the pause press is dropped.
- POINT_WAIT:
  - Frame counter decrements on each frame_tick.
  - When it is 0 and frame_tick occurs, go to REINIT.
  - PAUSE_FRAMES = 0 → leave on the first frame_tick.
  - Buttons are ignored.
- MATCH_OVER:
  - Scores and match_winner hold.
  - start_btn → clear scores, last_point, match_winner; go to REINIT.
- Engine reports with phys_valid = 0 are never used. Reports outside PLAY are ignored.
- Widths:
  - Scores are 4-bit unsigned.
  - Pause counter is 8-bit (PAUSE_FRAMES ≤ 255).
  - Divider compares at DIV_W bits.
- paused outputs 0 outside PLAY.

Test Plan:
- Reset then idle (FRAME_DIV=4): hold rst 2 cycles then release; run 20 cycles, no start → phys_en never 1, state_o=0, all outputs 0.
- Start and frame rate (FRAME_DIV=4): start_btn pulse → next cycle phys_reinit=1 and state_o=1; then state_o=2; phys_en pulses exactly every 4 cycles, each 1 cycle wide.
- Point scoring (PAUSE_FRAMES=2, FRAME_DIV=4):
  - In PLAY, drive phys_valid=1, phys_game_over=1, phys_winner=2 for one cycle → p2_score=1, last_point=2, state_o=3.
  - After 3 frame_ticks, one phys_reinit pulse, then state_o=2.
  - phys_en stays 0 throughout POINT_WAIT.
- Pause: in PLAY, pause_btn → paused=1 and phys_en held 0 for 10 frames; second pause_btn → phys_en resumes on the next tick.
- Invalid report ignored: phys_game_over=1 with phys_valid=0, or with phys_winner=0 or 3 → scores unchanged, state stays PLAY.
- Match end (WIN_SCORE=3):
  - Three P1 points → p1_score=3, match_winner=1, state_o=4; further reports ignored.
  - start_btn → scores 0, match_winner 0, phys_reinit pulse.
  - rst asserted mid-POINT_WAIT → next cycle state_o=0 and all outputs 0.
